// File: rtl/mw_add_seq_if.sv
// mw_add_seq_if: request and result handshakes of mw_add_seq; res_ovf exists only with MW_ADD_OVF_EN.
interface mw_add_seq_if #(parameter int WORDS = 4);
  logic req_valid, req_ready, op_ci, res_valid, res_ready, res_co;
  logic [32*WORDS-1:0] op_a, op_b, res_sum;
`ifdef MW_ADD_OVF_EN
  logic res_ovf;
  modport master(output req_valid, op_a, op_b, op_ci, res_ready,
                 input req_ready, res_valid, res_sum, res_co, res_ovf);
  modport slave(input req_valid, op_a, op_b, op_ci, res_ready,
                output req_ready, res_valid, res_sum, res_co, res_ovf);
`else
  modport master(output req_valid, op_a, op_b, op_ci, res_ready,
                 input req_ready, res_valid, res_sum, res_co);
  modport slave(input req_valid, op_a, op_b, op_ci, res_ready,
                output req_ready, res_valid, res_sum, res_co);
`endif
endinterface

// File: rtl/mw_add_seq.sv
// mw_add_seq: sequences a WORDS x 32-bit add through a registered 32-bit adder, LS word first.
// Optional MW_ADD_OVF_EN adds res_ovf (signed overflow of the wide add).
module mw_add_seq #(
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  mw_add_seq_if.slave bus,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_ci,
  input  logic [31:0] add_s,
  input  logic        add_co
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;
  state_t state, state_nx;
  logic [WORDS-1:0][31:0] a_reg, b_reg, sum_reg;
  logic carry;
  logic [IW-1:0] idx;
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.req_valid ? DRIVE : IDLE;
      DRIVE:   state_nx = CAPTURE;
      CAPTURE: state_nx = idx == LAST ? DONE : DRIVE;
      DONE:    state_nx = bus.res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // the carry register is the only link between consecutive words
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      a_reg <= bus.op_a;
      b_reg <= bus.op_b;
      carry <= bus.op_ci;
      idx   <= '0;
    end else if (state == CAPTURE) begin
      sum_reg[idx] <= add_s;
      carry        <= add_co;
      if (idx != LAST) idx <= idx + 1'b1;
    end
  end
  assign add_a         = a_reg[idx];
  assign add_b         = b_reg[idx];
  assign add_ci        = carry;
  assign bus.req_ready = state == IDLE;
  assign bus.res_valid = state == DONE;
  assign bus.res_sum   = sum_reg;
  assign bus.res_co    = carry;
`ifdef MW_ADD_OVF_EN
  assign bus.res_ovf = state == DONE && a_reg[WORDS-1][31] == b_reg[WORDS-1][31]
                       && sum_reg[WORDS-1][31] != a_reg[WORDS-1][31];
`endif
endmodule

// File: tb/tb_mw_add_seq.sv
// tb_mw_add_seq: directed checks of mw_add_seq against a behavioural registered 32-bit adder.
module tb_mw_add_seq;
  localparam int WORDS = 4;
  localparam int N = 32 * WORDS;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] add_a, add_b, add_s;
  logic add_ci, add_co;
  int checks = 0, failures = 0;
  mw_add_seq_if #(.WORDS(WORDS)) bus();
  mw_add_seq #(.WORDS(WORDS)) dut (
    .clock(clk), .reset(rst), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) {add_co, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};
  task automatic run_req(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                         output int lat, output logic [3:0] cim);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_ci = ci;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    cim = '0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      if (lat % 2 == 0 && lat < 8) cim[lat/2] = add_ci;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    checks++; if (bus.res_sum !== '0) begin failures++; $display("FAIL reset_res_sum got %h want 0", bus.res_sum); end
    checks++; if (bus.res_co !== 1'b0) begin failures++; $display("FAIL reset_res_co got %b want 0", bus.res_co); end
    checks++; if (add_a !== 32'd0 || add_b !== 32'd0 || add_ci !== 1'b0) begin
      failures++; $display("FAIL reset_adder_inputs got %h %h %b want 0 0 0", add_a, add_b, add_ci);
    end
  endtask
  task automatic test_carry_wrap;
    int lat;
    logic [3:0] cim;
    run_req({N{1'b1}}, '0, 1'b1, lat, cim);
    checks++; if (lat !== 8) begin failures++; $display("FAIL wrap_latency got %0d want 8", lat); end
    checks++; if (bus.res_sum !== '0) begin failures++; $display("FAIL wrap_sum got %h want 0", bus.res_sum); end
    checks++; if (bus.res_co !== 1'b1) begin failures++; $display("FAIL wrap_co got %b want 1", bus.res_co); end
    checks++; if (cim !== 4'b1111) begin failures++; $display("FAIL wrap_drive_ci got %b want 1111", cim); end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL wrap_release got ready=%b valid=%b want 1 0", bus.req_ready, bus.res_valid);
    end
  endtask
  task automatic test_word_carry;
    int lat;
    logic [3:0] cim;
    run_req(128'h0000_0000_0000_0000_0000_FFFF_FFFF_FFFF, 128'd1, 1'b0, lat, cim);
    checks++; if (bus.res_sum !== 128'h0000_0000_0000_0000_0001_0000_0000_0000) begin
      failures++; $display("FAIL word_carry_sum got %h want 00000000000000000001000000000000", bus.res_sum);
    end
    checks++; if (bus.res_co !== 1'b0 || lat !== 8) begin
      failures++; $display("FAIL word_carry_co got co=%b lat=%0d want 0 8", bus.res_co, lat);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask
  task automatic test_busy_backpressure;
    int lat;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op_a = 128'd5;
    bus.op_b = 128'd7;
    bus.op_ci = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL busy_req_ready got %b want 0", bus.req_ready); end
    bus.req_valid = 1'b1;
    bus.op_a = {N{1'b1}};
    bus.op_b = {N{1'b1}};
    bus.op_ci = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++; if (bus.res_sum !== 128'd12 || bus.res_co !== 1'b0) begin
      failures++; $display("FAIL busy_result got %h co=%b want c co=0", bus.res_sum, bus.res_co);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 128'd12 || bus.res_co !== 1'b0) begin
        failures++; $display("FAIL hold_%0d got valid=%b sum=%h co=%b want 1 c 0", i, bus.res_valid, bus.res_sum, bus.res_co);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL hold_release got ready=%b valid=%b want 1 0", bus.req_ready, bus.res_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL stale_request got ready=%b want 1", bus.req_ready); end
  endtask
  task automatic test_reset_mid;
    int lat;
    logic [3:0] cim;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op_a = {N{1'b1}};
    bus.op_b = {N{1'b1}};
    bus.op_ci = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_state got ready=%b valid=%b want 1 0", bus.req_ready, bus.res_valid);
    end
    checks++; if (bus.res_sum !== '0 || add_a !== 32'd0 || add_ci !== 1'b0) begin
      failures++; $display("FAIL midreset_clear got sum=%h a=%h ci=%b want 0 0 0", bus.res_sum, add_a, add_ci);
    end
    run_req(128'h135F_A562_0000_FFFF_0000_0000_135F_A562, 128'h3561_4642_FFFF_0000_0000_0000_3561_4642, 1'b0, lat, cim);
    checks++; if (bus.res_sum !== 128'h48C0_EBA4_FFFF_FFFF_0000_0000_48C0_EBA4 || bus.res_co !== 1'b0) begin
      failures++; $display("FAIL after_reset_sum got %h co=%b want 48c0eba4ffffffff0000000048c0eba4 co=0", bus.res_sum, bus.res_co);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask
`ifdef MW_ADD_OVF_EN
  task automatic test_ovf;
    int lat;
    logic [3:0] cim;
    @(negedge clk);
    checks++; if (bus.res_ovf !== 1'b0) begin failures++; $display("FAIL ovf_idle got %b want 0", bus.res_ovf); end
    run_req({1'b0, {N-1{1'b1}}}, 128'd1, 1'b0, lat, cim);
    checks++; if (bus.res_sum !== {1'b1, {N-1{1'b0}}} || bus.res_co !== 1'b0 || bus.res_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_set got %h co=%b ovf=%b want 8000..0 0 1", bus.res_sum, bus.res_co, bus.res_ovf);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    run_req({1'b0, {N-1{1'b1}}}, '0, 1'b0, lat, cim);
    checks++; if (bus.res_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", bus.res_ovf); end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask
`endif
  initial begin
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_ci = 1'b0;
    test_reset;
    test_carry_wrap;
    test_word_carry;
    test_busy_backpressure;
    test_reset_mid;
`ifdef MW_ADD_OVF_EN
    test_ovf;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
